elevator_scheduler: RTL

//  Top-level request scheduler for the 3-floor car. Latches call buttons into a

---
 rtl/elevator_scheduler_pkg.sv | 29 ++
 rtl/elevator_scheduler_scan_picker.sv | 64 ++++++
 rtl/elevator_scheduler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/elevator_scheduler_pkg.sv
// Shared types for the 3-floor car scheduler: floor labels, FSM states,
// scan directions and a floor-to-one-hot helper.
package elevator_scheduler_pkg;

    typedef enum logic [1:0] {
        F1 = 2'b00,
        F2 = 2'b01,
        F3 = 2'b10
    } floor_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DISPATCH = 3'd1,
        S_TRAVEL   = 3'd2,
        S_DOOR     = 3'd3,
        S_CLOSE    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_e;

    function automatic logic [2:0] fl_oh(floor_e f);
        fl_oh = 3'b001 << f;
    endfunction

endpackage

// File: rtl/elevator_scheduler_scan_picker.sv
// SCAN target selection: nearest pending floor in the current direction,
// otherwise nearest in the opposite one; an idle car prefers up.
module scan_picker
    import elevator_scheduler_pkg::*;
(
    input  logic [2:0] pending_i,
    input  floor_e     cur_i,
    input  dir_e       dir_i,
    output floor_e     target_o,
    output dir_e       dir_o,
    output logic       valid_o
);

    logic   up_vld;
    logic   dn_vld;
    floor_e up_tgt;
    floor_e dn_tgt;

    always_comb begin
        up_vld = 1'b0;
        dn_vld = 1'b0;
        up_tgt = F3;
        dn_tgt = F1;
        case (cur_i)
            F1: begin
                up_vld = |pending_i[2:1];
                up_tgt = pending_i[1] ? F2 : F3;
            end
            F2: begin
                up_vld = pending_i[2];
                dn_vld = pending_i[0];
            end
            F3: begin
                dn_vld = |pending_i[1:0];
                dn_tgt = pending_i[1] ? F2 : F1;
            end
            default: ;
        endcase
    end

    always_comb begin
        target_o = cur_i;
        dir_o    = dir_i;
        valid_o  = up_vld | dn_vld;
        if (dir_i == DIR_DOWN) begin
            if (dn_vld) begin
                target_o = dn_tgt;
                dir_o    = DIR_DOWN;
            end else if (up_vld) begin
                target_o = up_tgt;
                dir_o    = DIR_UP;
            end
        end else begin
            if (up_vld) begin
                target_o = up_tgt;
                dir_o    = DIR_UP;
            end else if (dn_vld) begin
                target_o = dn_tgt;
                dir_o    = DIR_DOWN;
            end
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// Request scheduler for the 3-floor car: latches calls, dispatches one
// target at a time to movement, supervises travel and sequences the door.
module elevator_scheduler
    import elevator_scheduler_pkg::*;
#(
    parameter int DOOR_TICKS = 4,
    parameter int TRAVEL_MAX = 8,
    parameter int TW         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn,
    input  logic       floor1,
    input  logic       floor2,
    input  logic       floor3,
    input  logic       moving,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic       door_open,
    output logic       dir_up,
    output logic       dir_down,
    output logic [2:0] pending,
    output logic       fault
);

    state_e          state_q, state_d;
    floor_e          cur_q, cur_d;
    floor_e          tgt_q, tgt_d;
    dir_e            dir_q, dir_d;
    logic [2:0]      pend_q, pend_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            fault_q, fault_d;

    logic [2:0]      floors;
    logic [2:0]      clr;
    logic [2:0]      set;
    logic [2:0]      led;
    floor_e          pick_tgt;
    dir_e            pick_dir;
    logic            pick_vld;

    assign floors = {floor3, floor2, floor1};

    scan_picker u_picker (
        .pending_i (pend_q),
        .cur_i     (cur_q),
        .dir_i     (dir_q),
        .target_o  (pick_tgt),
        .dir_o     (pick_dir),
        .valid_o   (pick_vld)
    );

    // Floor position only moves on a clean one-hot indication.
    always_comb begin
        cur_d = cur_q;
        case (floors)
            3'b001:  cur_d = F1;
            3'b010:  cur_d = F2;
            3'b100:  cur_d = F3;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        tgt_d   = tgt_q;
        tmr_d   = tmr_q;
        fault_d = fault_q;
        clr     = 3'b000;
        set     = btn;
        if (state_q == S_DOOR) set = btn & ~fl_oh(cur_q);
        case (state_q)
            S_IDLE: begin
                if (pend_q == 3'b000) begin
                    dir_d = DIR_IDLE;
                end else if ((pend_q & fl_oh(cur_q)) != 3'b000) begin
                    clr     = fl_oh(cur_q);
                    tmr_d   = TW'(DOOR_TICKS);
                    state_d = S_DOOR;
                end else if (pick_vld) begin
                    tgt_d   = pick_tgt;
                    dir_d   = pick_dir;
                    state_d = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                tmr_d   = TW'(TRAVEL_MAX);
                state_d = S_TRAVEL;
            end
            S_TRAVEL: begin
                if (floors == fl_oh(tgt_q) && !moving) begin
                    clr     = fl_oh(tgt_q);
                    tmr_d   = TW'(DOOR_TICKS);
                    state_d = S_DOOR;
                end else if (tmr_q <= TW'(1)) begin
                    fault_d = 1'b1;
                    tmr_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_DOOR: begin
                clr = fl_oh(cur_q);
                if ((btn & fl_oh(cur_q)) != 3'b000) begin
                    tmr_d = TW'(DOOR_TICKS);
                end else if (tmr_q <= TW'(1)) begin
                    tmr_d   = '0;
                    state_d = S_CLOSE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_CLOSE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        pend_d = (pend_q & ~clr) | set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= F1;
            tgt_q   <= F1;
            dir_q   <= DIR_IDLE;
            pend_q  <= 3'b000;
            tmr_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            tmr_q   <= tmr_d;
            fault_q <= fault_d;
        end
    end

    // Target request is only visible while the car is being sent there.
    assign led = (state_q == S_DISPATCH || state_q == S_TRAVEL)
               ? fl_oh(tgt_q) : 3'b000;

    assign led1      = led[0];
    assign led2      = led[1];
    assign led3      = led[2];
    assign door_open = (state_q == S_DOOR);
    assign dir_up    = (dir_q == DIR_UP);
    assign dir_down  = (dir_q == DIR_DOWN);
    assign pending   = pend_q;
    assign fault     = fault_q;

endmodule
